// File: rtl/fetch_byte_queue.sv
// Fetch-to-decode1 byte queue: 8-byte line entries presented as a 16-byte EIP-contiguous window.
// Push-to-window latency 1 cycle; dec1_stall is registered and deasserts while the queue is full.
module fetch_byte_queue #(
    parameter int ENTRIES = 4
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic [63:0]  fetch_bytes,
    input  logic [31:0]  fetch_pc,
    input  logic         fetch_not_ready,
    input  logic         page_bound,
    input  logic [3:0]   fetch_width,
    input  logic [3:0]   br_fetch_id,
    input  logic         fetch_bpred_taken,
    input  logic         flush,
    input  logic         dec_consume,
    input  logic [4:0]   dec_consume_len,
    output logic         dec1_stall,
    output logic [127:0] win_bytes,
    output logic [31:0]  win_eip,
    output logic [4:0]   win_cnt,
    output logic [3:0]   win_br_id,
    output logic         win_bpred_taken,
    output logic         consume_err
);

    localparam int AW = $clog2(ENTRIES);
    localparam int CW = AW + 1;

    logic [31:0]   r_pc    [ENTRIES];
    logic [63:0]   r_bytes [ENTRIES];
    logic [3:0]    r_len   [ENTRIES];
    logic [3:0]    r_br_id [ENTRIES];
    logic          r_bpred [ENTRIES];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [2:0]    r_hd_off;
    logic          r_stall;
    logic          r_err;

    logic [AW-1:0] w_nx_ptr;
    logic [31:0]   w_hd_pc;
    logic [63:0]   w_hd_bytes;
    logic [3:0]    w_hd_len;
    logic [31:0]   w_nx_pc;
    logic [63:0]   w_nx_bytes;
    logic [3:0]    w_nx_len;
    logic [3:0]    w_rem;
    logic          w_contig;
    logic [4:0]    w_win_cnt;
    logic [127:0]  w_win_bytes;
    logic [4:0]    w_pos;
    logic [4:0]    w_npos;

    logic          w_push;
    logic [3:0]    w_push_len;
    logic          w_legal;
    logic          w_illegal;
    logic [4:0]    w_t;
    logic [4:0]    w_t2;
    logic [1:0]    w_pops;
    logic [2:0]    w_hd_off_nxt;
    logic [CW-1:0] w_count_nxt;

    assign w_nx_ptr   = r_rd_ptr + 1'b1;
    assign w_hd_pc    = r_pc[r_rd_ptr];
    assign w_hd_bytes = r_bytes[r_rd_ptr];
    assign w_hd_len   = r_len[r_rd_ptr];
    assign w_nx_pc    = r_pc[w_nx_ptr];
    assign w_nx_bytes = r_bytes[w_nx_ptr];
    assign w_nx_len   = r_len[w_nx_ptr];

    assign w_rem    = w_hd_len - {1'b0, r_hd_off};
    assign w_contig = (r_count >= CW'(2)) && (w_nx_pc == (w_hd_pc + {28'd0, w_hd_len}));

    always_comb begin
        w_win_cnt = 5'd0;
        if (r_count != '0) begin
            if (!w_contig) begin
                w_win_cnt = {1'b0, w_rem};
            end else if (({1'b0, w_rem} + {1'b0, w_nx_len}) > 5'd16) begin
                w_win_cnt = 5'd16;
            end else begin
                w_win_cnt = {1'b0, w_rem} + {1'b0, w_nx_len};
            end
        end
    end

    // Window bytes run past the head line into the next entry; bytes past win_cnt are don't-care.
    always_comb begin
        w_win_bytes = '0;
        w_pos       = '0;
        w_npos      = '0;
        for (int i = 0; i < 16; i++) begin
            w_pos = {2'b00, r_hd_off} + 5'(i);
            if (w_pos < {1'b0, w_hd_len}) begin
                w_win_bytes[i*8 +: 8] = w_hd_bytes[{w_pos[2:0], 3'b000} +: 8];
            end else begin
                w_npos = w_pos - {1'b0, w_hd_len};
                if (w_npos < 5'd8) begin
                    w_win_bytes[i*8 +: 8] = w_nx_bytes[{w_npos[2:0], 3'b000} +: 8];
                end
            end
        end
    end

    assign w_push     = !fetch_not_ready && r_stall && !flush;
    assign w_push_len = (!page_bound || fetch_width == 4'd0 || fetch_width > 4'd8) ? 4'd8 : fetch_width;

    assign w_legal   = dec_consume && (dec_consume_len != 5'd0) && (dec_consume_len <= w_win_cnt);
    assign w_illegal = dec_consume && !w_legal;
    assign w_t       = {2'b00, r_hd_off} + dec_consume_len;

    always_comb begin
        w_pops       = 2'd0;
        w_hd_off_nxt = r_hd_off;
        w_t2         = 5'd0;
        if (w_legal) begin
            if (w_t < {1'b0, w_hd_len}) begin
                w_hd_off_nxt = w_t[2:0];
            end else begin
                w_t2   = w_t - {1'b0, w_hd_len};
                w_pops = 2'd1;
                if ((r_count >= CW'(2)) && (w_t2 == {1'b0, w_nx_len})) begin
                    w_pops       = 2'd2;
                    w_hd_off_nxt = 3'd0;
                end else begin
                    w_hd_off_nxt = w_t2[2:0];
                end
            end
        end
    end

    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pops);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_pc[i]    <= '0;
                r_bytes[i] <= '0;
                r_len[i]   <= '0;
                r_br_id[i] <= '0;
                r_bpred[i] <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hd_off <= '0;
            r_stall  <= 1'b1;
            r_err    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hd_off <= '0;
            r_stall  <= 1'b1;
        end else begin
            if (w_push) begin
                r_pc[r_wr_ptr]    <= fetch_pc;
                r_bytes[r_wr_ptr] <= fetch_bytes;
                r_len[r_wr_ptr]   <= w_push_len;
                r_br_id[r_wr_ptr] <= br_fetch_id;
                r_bpred[r_wr_ptr] <= fetch_bpred_taken;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= r_rd_ptr + AW'(w_pops);
            r_hd_off <= w_hd_off_nxt;
            r_count  <= w_count_nxt;
            // A slot freed by this cycle's pop only becomes offerable next cycle.
            r_stall  <= (w_count_nxt <= CW'(ENTRIES - 1));
            if (w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign dec1_stall      = r_stall;
    assign win_bytes       = w_win_bytes;
    assign win_eip         = w_hd_pc + {29'd0, r_hd_off};
    assign win_cnt         = w_win_cnt;
    assign win_br_id       = r_br_id[r_rd_ptr];
    assign win_bpred_taken = r_bpred[r_rd_ptr];
    assign consume_err     = r_err;

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Bench for fetch_byte_queue: directed scenarios then random traffic against a line-queue model.
module tb_fetch_byte_queue;
    localparam int ENTRIES = 4;

    logic         CLK = 1'b0;
    logic         reset;
    logic [63:0]  fetch_bytes;
    logic [31:0]  fetch_pc;
    logic         fetch_not_ready;
    logic         page_bound;
    logic [3:0]   fetch_width;
    logic [3:0]   br_fetch_id;
    logic         fetch_bpred_taken;
    logic         flush;
    logic         dec_consume;
    logic [4:0]   dec_consume_len;
    logic         dec1_stall;
    logic [127:0] win_bytes;
    logic [31:0]  win_eip;
    logic [4:0]   win_cnt;
    logic [3:0]   win_br_id;
    logic         win_bpred_taken;
    logic         consume_err;

    fetch_byte_queue #(.ENTRIES(ENTRIES)) dut (
        .CLK(CLK), .reset(reset),
        .fetch_bytes(fetch_bytes), .fetch_pc(fetch_pc),
        .fetch_not_ready(fetch_not_ready), .page_bound(page_bound),
        .fetch_width(fetch_width), .br_fetch_id(br_fetch_id),
        .fetch_bpred_taken(fetch_bpred_taken), .flush(flush),
        .dec_consume(dec_consume), .dec_consume_len(dec_consume_len),
        .dec1_stall(dec1_stall), .win_bytes(win_bytes), .win_eip(win_eip),
        .win_cnt(win_cnt), .win_br_id(win_br_id),
        .win_bpred_taken(win_bpred_taken), .consume_err(consume_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [63:0] bytes;
        int          len;
        logic [3:0]  br;
        logic        bp;
    } ent_t;

    ent_t mq[$];
    int   moff;
    bit   mstall;
    bit   merr;
    bit   m_acc;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [63:0] mkbytes(input logic [31:0] pc);
        logic [63:0] b;
        logic [31:0] a;
        for (int i = 0; i < 8; i++) begin
            a = pc + 32'(i);
            b[i*8 +: 8] = a[7:0];
        end
        return b;
    endfunction

    // Bytes available from the head: the rest of the head line plus the next line if it follows in EIP.
    function automatic int exp_cnt();
        int rem;
        if (mq.size() == 0) return 0;
        rem = mq[0].len - moff;
        if (mq.size() >= 2 && mq[1].pc == mq[0].pc + 32'(mq[0].len))
            return (rem + mq[1].len > 16) ? 16 : rem + mq[1].len;
        return rem;
    endfunction

    function automatic logic [127:0] exp_bytes(input int cnt);
        logic [127:0] r = '0;
        int p = moff;
        int e = 0;
        for (int k = 0; k < cnt; k++) begin
            if (p >= mq[e].len) begin
                p = 0;
                e++;
            end
            r[k*8 +: 8] = mq[e].bytes[p*8 +: 8];
            p++;
        end
        return r;
    endfunction

    function automatic logic [127:0] byte_mask(input int cnt);
        logic [127:0] m = '0;
        for (int k = 0; k < cnt; k++) m[k*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        int c;
        c = exp_cnt();
        chk("win_cnt", 128'(win_cnt), 128'(c));
        chk("dec1_stall", 128'(dec1_stall), 128'(mstall));
        chk("consume_err", 128'(consume_err), 128'(merr));
        if (mq.size() > 0) begin
            chk("win_eip", 128'(win_eip), 128'(mq[0].pc + 32'(moff)));
            chk("win_br_id", 128'(win_br_id), 128'(mq[0].br));
            chk("win_bpred", 128'(win_bpred_taken), 128'(mq[0].bp));
            chk("win_bytes", win_bytes & byte_mask(c), exp_bytes(c));
        end
    endtask

    task automatic model_reset();
        mq.delete();
        moff   = 0;
        mstall = 1'b1;
        merr   = 1'b0;
    endtask

    // One clock with the currently driven inputs; the model advances from the pre-edge state.
    task automatic step();
        int   wc;
        int   len;
        ent_t e;
        wc = exp_cnt();
        @(posedge CLK);
        #1;
        m_acc = 1'b0;
        if (flush) begin
            mq.delete();
            moff   = 0;
            mstall = 1'b1;
        end else begin
            m_acc = !fetch_not_ready && mstall;
            if (dec_consume) begin
                len = int'(dec_consume_len);
                if (len >= 1 && len <= wc) begin
                    moff += len;
                    while (mq.size() > 0 && moff >= mq[0].len) begin
                        moff -= mq[0].len;
                        void'(mq.pop_front());
                    end
                end else begin
                    merr = 1'b1;
                end
            end
            if (m_acc) begin
                e.pc    = fetch_pc;
                e.bytes = fetch_bytes;
                e.len   = (page_bound && fetch_width != 0) ? int'(fetch_width) : 8;
                e.br    = br_fetch_id;
                e.bp    = fetch_bpred_taken;
                mq.push_back(e);
            end
            mstall = (mq.size() <= ENTRIES - 1);
        end
        check_all();
    endtask

    // fv: offer a line; cl < 0: no consume; fl: flush.
    task automatic cyc(input bit fv, input logic [31:0] pc, input bit pb, input logic [3:0] fw,
                       input int cl, input bit fl);
        fetch_not_ready   = !fv;
        fetch_pc          = pc;
        fetch_bytes       = mkbytes(pc);
        page_bound        = pb;
        fetch_width       = fw;
        br_fetch_id       = 4'($urandom);
        fetch_bpred_taken = 1'($urandom);
        flush             = fl;
        dec_consume       = (cl >= 0);
        dec_consume_len   = (cl >= 0) ? 5'(cl) : 5'd0;
        step();
    endtask

    task automatic random_phase(input int cycles, input bit allow_bad);
        logic [31:0] npc;
        logic [31:0] pc;
        bit          fv;
        bit          pb;
        bit          fl;
        logic [3:0]  fw;
        int          wc;
        int          cl;
        npc = 32'h4000_0000;
        for (int n = 0; n < cycles; n++) begin
            fv = ($urandom % 4) != 0;
            pb = ($urandom % 5) == 0;
            fw = 4'($urandom_range(0, 8));
            fl = ($urandom % 40) == 0;
            wc = exp_cnt();
            cl = -1;
            if (allow_bad && ($urandom % 15) == 0) cl = $urandom_range(0, 16);
            else if (($urandom % 3) != 0 && wc > 0) cl = $urandom_range(1, wc);
            pc = npc;
            cyc(fv, pc, pb, fw, cl, fl);
            if (fl) npc = $urandom & 32'hFFFF_FFF8;
            else if (m_acc) npc = (($urandom % 6) == 0) ? $urandom : pc + ((pb && fw != 0) ? 32'(fw) : 32'd8);
        end
    endtask

    initial begin
        reset             = 1'b0;
        fetch_not_ready   = 1'b1;
        fetch_pc          = '0;
        fetch_bytes       = '0;
        page_bound        = 1'b0;
        fetch_width       = '0;
        br_fetch_id       = '0;
        fetch_bpred_taken = 1'b0;
        flush             = 1'b0;
        dec_consume       = 1'b0;
        dec_consume_len   = '0;
        model_reset();
        #12;
        chk("rst_win_cnt", 128'(win_cnt), 128'd0);
        chk("rst_win_eip", 128'(win_eip), 128'd0);
        chk("rst_stall", 128'(dec1_stall), 128'd1);
        chk("rst_err", 128'(consume_err), 128'd0);
        chk("rst_br_id", 128'(win_br_id), 128'd0);
        chk("rst_bpred", 128'(win_bpred_taken), 128'd0);
        chk("rst_bytes", win_bytes, 128'd0);
        reset = 1'b1;

        // Single line becomes visible one cycle after push.
        cyc(1, 32'h1000, 0, 0, -1, 0);
        chk("t1_cnt", 128'(win_cnt), 128'd8);
        chk("t1_eip", 128'(win_eip), 128'h1000);
        chk("t1_byte0", 128'(win_bytes[7:0]), 128'h00);
        chk("t1_byte7", 128'(win_bytes[63:56]), 128'h07);
        cyc(0, 0, 0, 0, 8, 0);
        chk("t1_empty", 128'(win_cnt), 128'd0);

        // Two contiguous lines form a 16-byte window.
        cyc(1, 32'h1000, 0, 0, -1, 0);
        cyc(1, 32'h1008, 0, 0, -1, 0);
        chk("t2_cnt16", 128'(win_cnt), 128'd16);
        cyc(0, 0, 0, 0, 3, 0);
        chk("t2_eip", 128'(win_eip), 128'h1003);
        chk("t2_cnt", 128'(win_cnt), 128'd13);
        cyc(0, 0, 0, 0, 13, 0);
        chk("t2_empty", 128'(win_cnt), 128'd0);

        // Discontinuity stops the window at the head line.
        cyc(1, 32'h1000, 0, 0, -1, 0);
        cyc(1, 32'h2000, 0, 0, -1, 0);
        chk("t3_cnt", 128'(win_cnt), 128'd8);
        cyc(0, 0, 0, 0, 8, 0);
        chk("t3_eip", 128'(win_eip), 128'h2000);
        chk("t3_cnt2", 128'(win_cnt), 128'd8);
        cyc(0, 0, 0, 0, 8, 0);

        // Page-truncated line followed by the next page.
        cyc(1, 32'h1FFC, 1, 4, -1, 0);
        cyc(1, 32'h2000, 0, 0, -1, 0);
        chk("t4_cnt", 128'(win_cnt), 128'd12);
        cyc(0, 0, 0, 0, 6, 0);
        chk("t4_eip", 128'(win_eip), 128'h2002);
        chk("t4_cnt2", 128'(win_cnt), 128'd6);
        cyc(0, 0, 0, 0, 6, 0);

        // Full queue drops an offered line; double pop wraps the read pointer.
        cyc(1, 32'h1000, 0, 0, -1, 0);
        cyc(1, 32'h1008, 0, 0, -1, 0);
        cyc(1, 32'h1010, 0, 0, -1, 0);
        chk("t5_stall3", 128'(dec1_stall), 128'd1);
        cyc(1, 32'h1018, 0, 0, -1, 0);
        chk("t5_full", 128'(dec1_stall), 128'd0);
        cyc(1, 32'h1020, 0, 0, -1, 0);
        chk("t5_drop_eip", 128'(win_eip), 128'h1000);
        cyc(0, 0, 0, 0, 16, 0);
        chk("t5_stall_rel", 128'(dec1_stall), 128'd1);
        chk("t5_eip", 128'(win_eip), 128'h1010);
        chk("t5_cnt", 128'(win_cnt), 128'd16);
        cyc(0, 0, 0, 0, 16, 0);
        chk("t5_drained", 128'(win_cnt), 128'd0);
        cyc(1, 32'h1020, 0, 0, -1, 0);
        cyc(1, 32'h1028, 0, 0, -1, 0);
        chk("t5_wrap_cnt", 128'(win_cnt), 128'd16);
        cyc(0, 0, 0, 0, 10, 0);
        chk("t5_wrap_eip", 128'(win_eip), 128'h102A);

        // Flush beats a same-cycle push and consume.
        cyc(1, 32'h3000, 0, 0, 4, 1);
        chk("t6_flush_cnt", 128'(win_cnt), 128'd0);
        chk("t6_flush_stall", 128'(dec1_stall), 128'd1);
        cyc(1, 32'h1000, 0, 0, -1, 0);
        cyc(0, 0, 0, 0, 9, 0);
        chk("t6_err", 128'(consume_err), 128'd1);
        chk("t6_cnt", 128'(win_cnt), 128'd8);
        chk("t6_eip", 128'(win_eip), 128'h1000);

        random_phase(400, 1'b1);

        // Asynchronous reset mid-stream.
        cyc(1, 32'h5000, 0, 0, -1, 0);
        reset = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_cnt", 128'(win_cnt), 128'd0);
        chk("mid_rst_eip", 128'(win_eip), 128'd0);
        chk("mid_rst_stall", 128'(dec1_stall), 128'd1);
        chk("mid_rst_err", 128'(consume_err), 128'd0);
        chk("mid_rst_br", 128'(win_br_id), 128'd0);
        chk("mid_rst_bp", 128'(win_bpred_taken), 128'd0);
        @(posedge CLK);
        #1;
        reset = 1'b1;

        random_phase(300, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
